// File: rtl/voice_mix_sequencer.sv
// voice_mix_sequencer
// Mixes NUM_VOICES unsigned oscillator samples into one saturated output
// sample per frame by time-sharing a single external WIDTH-bit adder, then
// offers the result on a valid/ready interface.
module voice_mix_sequencer #(
    parameter int WIDTH      = 12,
    parameter int NUM_VOICES = 4,
    parameter int SEL_W      = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [SEL_W-1:0] o_voice_sel,
    input  logic [WIDTH-1:0] i_voice_sample,
    output logic [WIDTH-1:0] o_add_lhs,
    output logic [WIDTH-1:0] o_add_rhs,
    input  logic [WIDTH-1:0] i_add_result,
    input  logic             i_add_overflow,
    output logic [WIDTH-1:0] o_mix_out,
    output logic             o_mix_valid,
    input  logic             i_mix_ready,
    output logic             o_busy,
    output logic             o_sat,
    output logic             o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VOICES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [SEL_W-1:0] r_idx;
    logic             r_sat;
    logic             r_overrun;

    logic             w_handshake;
    logic             w_accept;
    logic             w_drop;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_sat;

    // A start is taken from IDLE, or in DONE only together with the handshake;
    // any other start is dropped and flagged one cycle later.
    assign w_handshake = (r_state == ST_DONE) && i_mix_ready;
    assign w_accept    = i_start && ((r_state == ST_IDLE) || w_handshake);
    assign w_drop      = i_start && ((r_state == ST_ACCUM) ||
                                     ((r_state == ST_DONE) && !i_mix_ready));
    assign w_last      = (r_idx == LAST_IDX);
    // A carry-out clamps to full scale; an all-ones acc then stays all-ones.
    assign w_sum_sat   = i_add_overflow ? {WIDTH{1'b1}} : i_add_result;

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_ACCUM;
                else         w_state_nxt = ST_IDLE;
            end
            ST_ACCUM: begin
                if (w_last) w_state_nxt = ST_DONE;
                else        w_state_nxt = ST_ACCUM;
            end
            ST_DONE: begin
                if (w_handshake) w_state_nxt = i_start ? ST_ACCUM : ST_IDLE;
                else             w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Accumulator, voice index, sticky saturation flag and overrun pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= {WIDTH{1'b0}};
            r_idx     <= {SEL_W{1'b0}};
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_accept) begin
                r_acc <= {WIDTH{1'b0}};
                r_idx <= {SEL_W{1'b0}};
                r_sat <= 1'b0;
            end else if (r_state == ST_ACCUM) begin
                r_acc <= w_sum_sat;
                r_sat <= r_sat | i_add_overflow;
                if (!w_last) r_idx <= r_idx + SEL_W'(1'b1);
                else         r_idx <= r_idx;
            end else begin
                r_acc <= r_acc;
                r_idx <= r_idx;
                r_sat <= r_sat;
            end
        end
    end

    // Output decode; the shared adder is only driven during ACCUM.
    always_comb begin
        o_voice_sel = {SEL_W{1'b0}};
        o_add_lhs   = {WIDTH{1'b0}};
        o_add_rhs   = {WIDTH{1'b0}};
        if (r_state == ST_ACCUM) begin
            o_voice_sel = r_idx;
            o_add_lhs   = r_acc;
            o_add_rhs   = i_voice_sample;
        end else begin
            o_voice_sel = {SEL_W{1'b0}};
            o_add_lhs   = {WIDTH{1'b0}};
            o_add_rhs   = {WIDTH{1'b0}};
        end
        o_mix_out   = r_acc;
        o_mix_valid = (r_state == ST_DONE);
        o_busy      = (r_state != ST_IDLE);
        o_sat       = r_sat;
        o_overrun   = r_overrun;
    end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Directed self-checking bench for voice_mix_sequencer with a behavioural
// 12-bit adder and a four-entry voice sample table.
`timescale 1ns/1ps
module tb_voice_mix_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  voice_sel;
    logic [11:0] voice_sample;
    logic [11:0] add_lhs;
    logic [11:0] add_rhs;
    logic [11:0] add_result;
    logic        add_overflow;
    logic [11:0] mix_out;
    logic        mix_valid;
    logic        mix_ready;
    logic        busy;
    logic        sat;
    logic        overrun;

    logic [11:0] smp [4];
    int          n_checks;
    int          n_pass;

    voice_mix_sequencer #(.WIDTH(12), .NUM_VOICES(4), .SEL_W(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .o_voice_sel    (voice_sel),
        .i_voice_sample (voice_sample),
        .o_add_lhs      (add_lhs),
        .o_add_rhs      (add_rhs),
        .i_add_result   (add_result),
        .i_add_overflow (add_overflow),
        .o_mix_out      (mix_out),
        .o_mix_valid    (mix_valid),
        .i_mix_ready    (mix_ready),
        .o_busy         (busy),
        .o_sat          (sat),
        .o_overrun      (overrun)
    );

    assign voice_sample = smp[voice_sel];
    assign {add_overflow, add_result} = {1'b0, add_lhs} + {1'b0, add_rhs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs === exp_v) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_smp(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d);
        smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
    endtask

    task automatic run_frame(input string tag, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d,
                             input logic [11:0] exp_sum, input logic exp_sat);
        set_smp(a, b, c, d);
        mix_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_sel"}, 32'(voice_sel), 32'(i));
            chk({tag, "_rhs"}, 32'(add_rhs), 32'(smp[i]));
            chk({tag, "_validlow"}, 32'(mix_valid), 32'd0);
            tick();
        end
        chk({tag, "_valid"}, 32'(mix_valid), 32'd1);
        chk({tag, "_out"}, 32'(mix_out), 32'(exp_sum));
        chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
        chk({tag, "_lhs_idle"}, 32'(add_lhs), 32'd0);
        mix_ready = 1'b1;
        tick();
        mix_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(mix_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; start = 1'b0; mix_ready = 1'b0;
        set_smp(12'd0, 12'd0, 12'd0, 12'd0);
        tick(); tick();
        chk("rst_valid", 32'(mix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'(mix_out), 32'd0);
        chk("rst_sel", 32'(voice_sel), 32'd0);
        rst = 1'b0;
        tick();

        // T1 basic mix and voice_sel order
        run_frame("t1", 12'd5, 12'd5, 12'd10, 12'd10, 12'd30, 1'b0);
        // T2 saturation cases
        run_frame("t2a", 12'hFFF, 12'h001, 12'h000, 12'h000, 12'hFFF, 1'b1);
        run_frame("t2b", 12'h800, 12'h800, 12'h000, 12'h000, 12'hFFF, 1'b1);
        run_frame("t2c", 12'h7FF, 12'h800, 12'h000, 12'h000, 12'hFFF, 1'b0);

        // T3 backpressure in DONE, plus a dropped start while stalled
        set_smp(12'd100, 12'd200, 12'd300, 12'd400);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 32'(mix_valid), 32'd1);
            chk("t3_hold_out", 32'(mix_out), 32'd1000);
            tick();
        end
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_drop_ovr", 32'(overrun), 32'd1);
        chk("t3_drop_valid", 32'(mix_valid), 32'd1);
        chk("t3_drop_out", 32'(mix_out), 32'd1000);
        tick();
        chk("t3_ovr_clear", 32'(overrun), 32'd0);
        mix_ready = 1'b1; tick(); mix_ready = 1'b0;
        chk("t3_idle_busy", 32'(busy), 32'd0);
        chk("t3_idle_valid", 32'(mix_valid), 32'd0);

        // T4 start during ACCUM idx=2, then back-to-back from DONE
        set_smp(12'd1, 12'd2, 12'd3, 12'd4);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("t4_sel2", 32'(voice_sel), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_ovr", 32'(overrun), 32'd1);
        chk("t4_sel3", 32'(voice_sel), 32'd3);
        tick();
        chk("t4_ovr_clear", 32'(overrun), 32'd0);
        chk("t4_valid", 32'(mix_valid), 32'd1);
        chk("t4_out", 32'(mix_out), 32'd10);
        start = 1'b1; mix_ready = 1'b1; tick(); start = 1'b0; mix_ready = 1'b0;
        chk("t4_b2b_busy", 32'(busy), 32'd1);
        chk("t4_b2b_valid", 32'(mix_valid), 32'd0);
        chk("t4_b2b_sel", 32'(voice_sel), 32'd0);
        chk("t4_b2b_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_b2b_out", 32'(mix_out), 32'd10);
        chk("t4_b2b_vld", 32'(mix_valid), 32'd1);
        mix_ready = 1'b1; tick(); mix_ready = 1'b0;

        // T5 reset mid-frame at idx=1
        set_smp(12'd7, 12'd7, 12'd7, 12'd7);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t5_sel1", 32'(voice_sel), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(mix_valid), 32'd0);
        chk("t5_out", 32'(mix_out), 32'd0);
        chk("t5_sel", 32'(voice_sel), 32'd0);
        chk("t5_lhs", 32'(add_lhs), 32'd0);
        chk("t5_rhs", 32'(add_rhs), 32'd0);
        chk("t5_sat", 32'(sat), 32'd0);
        chk("t5_ovr", 32'(overrun), 32'd0);
        tick();
        chk("t5_still_idle", 32'(busy), 32'd0);
        run_frame("t5_fresh", 12'd7, 12'd7, 12'd7, 12'd7, 12'd28, 1'b0);

        // T6 ready tied high, start every 5 cycles for 10 frames
        mix_ready = 1'b1;
        for (int f = 1; f <= 10; f++) begin
            set_smp(12'(f), 12'(2 * f), 12'(3 * f), 12'(4 * f));
            start = 1'b1; tick(); start = 1'b0;
            chk("t6_busy", 32'(busy), 32'd1);
            for (int i = 0; i < 4; i++) begin
                chk("t6_ovr", 32'(overrun), 32'd0);
                tick();
            end
            chk("t6_valid", 32'(mix_valid), 32'd1);
            chk("t6_out", 32'(mix_out), 32'(10 * f));
        end
        tick();
        chk("t6_end_idle", 32'(busy), 32'd0);
        chk("t6_end_ovr", 32'(overrun), 32'd0);
        mix_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
